// File: rtl/gen_scheduler.sv
// Generation scheduler for the life engine: rotates an N-entry ring of cell buffers
// between engine and renderer, with run/pause, single-step and a frame-count speed gate.
module gen_scheduler #(
  parameter int NUM_BUFS = 2,
  parameter int SPEED_W  = 4,
  parameter int GEN_W    = 16,
  localparam int IDX_W   = $clog2(NUM_BUFS)
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               run_in,
  input  logic               step_in,
  input  logic [SPEED_W-1:0] speed_in,
  input  logic               buf_ready_in,
  input  logic               logic_done_in,
  input  logic               render_done_in,
  output logic               logic_start_out,
  output logic [IDX_W-1:0]   src_idx_out,
  output logic [IDX_W-1:0]   dst_idx_out,
  output logic [IDX_W-1:0]   disp_idx_out,
  output logic               busy_out,
  output logic [GEN_W-1:0]   gen_count_out
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   head;
  logic [IDX_W-1:0]   wr;
  logic [SPEED_W-1:0] frame_cnt;
  logic               step_pending;
  logic               start_ok;
  logic               start;
  logic               done_acc;

  function automatic logic [SPEED_W-1:0] sat_inc(input logic [SPEED_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Ring successor of the newest completed buffer; NUM_BUFS need not be a power of two.
  assign wr = (head == IDX_W'(NUM_BUFS - 1)) ? '0 : head + 1'b1;

  assign start_ok = buf_ready_in && (wr != disp_idx_out) &&
                    (run_in ? (frame_cnt >= speed_in) : step_pending);

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    done_acc  = 1'b0;
    case (state)
      S_IDLE: if (start_ok) begin
        start     = 1'b1;
        state_nxt = S_BUSY;
      end
      S_BUSY: if (logic_done_in) begin
        done_acc  = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head            <= '0;
      disp_idx_out    <= '0;
      src_idx_out     <= '0;
      dst_idx_out     <= IDX_W'(1);
      busy_out        <= 1'b0;
      logic_start_out <= 1'b0;
      gen_count_out   <= '0;
      frame_cnt       <= '0;
      step_pending    <= 1'b0;
    end else begin
      logic_start_out <= start;
      if (start) begin
        src_idx_out <= head;
        dst_idx_out <= wr;
        busy_out    <= 1'b1;
      end
      if (done_acc) begin
        head          <= dst_idx_out;
        gen_count_out <= gen_count_out + 1'b1;
        busy_out      <= 1'b0;
      end
      // A frame that ends as a generation completes shows the fresh buffer.
      if (render_done_in)
        disp_idx_out <= done_acc ? dst_idx_out : head;
      if (start)
        frame_cnt <= '0;
      else if (render_done_in)
        frame_cnt <= sat_inc(frame_cnt);
      // Steps only queue while paused; a start consumes any coincident pulse.
      if (start || run_in)
        step_pending <= 1'b0;
      else if (step_in)
        step_pending <= 1'b1;
    end
  end

endmodule
